// File: rtl/dfi_resp_pkg.sv
// ----------------------------------------------------------------------------
// dfi_resp_pkg
// Shared types and helpers for the DFI DRAM responder.
//   - cmd_e       : decoded DFI command
//   - decode_cmd  : {cke, cs_n, ras_n, cas_n, we_n} -> cmd_e
//   - store_idx_t : backing-store index {ba[1:0], row LSBs, column group}
// Default DFI widths for bank, address and chip-select are defined here.
// ----------------------------------------------------------------------------
package dfi_resp_pkg;

    localparam int DEF_BA_W   = 3;
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_CS_W   = 1;

    localparam int DATA_W        = 128;
    localparam int MASK_W        = DATA_W / 8;
    localparam int DEF_ROW_IDX_W = 2;
    localparam int DEF_COL_IDX_W = 2;
    localparam int STORE_IDX_W   = 2 + DEF_ROW_IDX_W + DEF_COL_IDX_W;

    typedef logic [STORE_IDX_W-1:0] store_idx_t;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_REF,
        CMD_MRS
    } cmd_e;

    // A command is only seen when the clock is enabled and rank 0 is selected.
    function automatic cmd_e decode_cmd(input logic cke, input logic cs_n0,
                                        input logic ras_n, input logic cas_n,
                                        input logic we_n);
        cmd_e cmd;
        cmd = CMD_NOP;
        if (cke && !cs_n0) begin
            unique case ({ras_n, cas_n, we_n})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_RD;
                3'b100:  cmd = CMD_WR;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                3'b000:  cmd = CMD_MRS;
                default: cmd = CMD_NOP;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/dfi_resp_fifo.sv
// ----------------------------------------------------------------------------
// dfi_resp_fifo
// Small synchronous FIFO holding store indices of accepted RD or WR commands
// until the matching data enable arrives.
//   clk, rst_n  : clock, synchronous active-low reset (pointers only)
//   push, push_data : write side; ignored while full
//   pop, pop_data   : read side; pop_data shows the head, pop ignored while empty
//   full, empty     : occupancy flags, reflecting state before this cycle's ops
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module dfi_resp_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dfi_dram_responder.sv
// ----------------------------------------------------------------------------
// dfi_dram_responder
// DRAM/PHY-side stand-in at the far end of a DFI bus. Decodes controller
// commands, tracks per-bank open rows, keeps a small 128-bit backing store,
// returns read beats RD_LAT cycles after dfi_rddata_en and raises sticky
// protocol error flags.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   dfi_cke, dfi_cs_n[0]            : command qualifiers
//   dfi_ras_n/cas_n/we_n, ba, addr  : command, bank, row / column+A10
//   dfi_odt                         : on-die termination
//   dfi_wrdata_en/wrdata/wrdata_mask: write beat (mask bit 1 = byte kept)
//   dfi_rddata_en                   : read beat request
//   dfi_rddata/valid/dnv            : returned read beat
//   err_protocol/wr_orphan/rd_orphan/overflow/odt : sticky error flags
// Build option: define DFI_RESP_ODT_CHK_EN to flag write beats issued with
// dfi_odt low on err_odt; otherwise err_odt is tied 0.
// ----------------------------------------------------------------------------
module dfi_dram_responder
    import dfi_resp_pkg::*;
#(
    parameter int BA_W       = DEF_BA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CS_W       = DEF_CS_W,
    parameter int ROW_IDX_W  = DEF_ROW_IDX_W,
    parameter int COL_IDX_W  = DEF_COL_IDX_W,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dfi_cke,
    input  logic [CS_W-1:0]   dfi_cs_n,
    input  logic              dfi_ras_n,
    input  logic              dfi_cas_n,
    input  logic              dfi_we_n,
    input  logic [BA_W-1:0]   dfi_ba,
    input  logic [ADDR_W-1:0] dfi_addr,
    input  logic              dfi_odt,
    input  logic              dfi_wrdata_en,
    input  logic [DATA_W-1:0] dfi_wrdata,
    input  logic [MASK_W-1:0] dfi_wrdata_mask,
    input  logic              dfi_rddata_en,
    output logic [DATA_W-1:0] dfi_rddata,
    output logic              dfi_rddata_valid,
    output logic [MASK_W-1:0] dfi_rddata_dnv,
    output logic              err_protocol,
    output logic              err_wr_orphan,
    output logic              err_rd_orphan,
    output logic              err_overflow,
    output logic              err_odt
);

    localparam int NUM_BANKS   = 1 << BA_W;
    localparam int IDX_W       = 2 + ROW_IDX_W + COL_IDX_W;
    localparam int STORE_DEPTH = 1 << IDX_W;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    cmd_e             cmd;
    logic             bank_hit;
    logic             a10;
    logic [IDX_W-1:0] cmd_idx;

    logic [NUM_BANKS-1:0] bank_open;
    logic [ROW_IDX_W-1:0] open_row [NUM_BANKS];

    assign cmd      = decode_cmd(dfi_cke, dfi_cs_n[0], dfi_ras_n, dfi_cas_n, dfi_we_n);
    assign bank_hit = bank_open[dfi_ba];
    assign a10      = dfi_addr[10];
    // One 128-bit beat covers 8 columns, hence the column group starts at bit 3.
    assign cmd_idx  = {dfi_ba[1:0], open_row[dfi_ba], dfi_addr[3 +: COL_IDX_W]};

    // ------------------------------------------------------------------
    // Command FIFOs
    // ------------------------------------------------------------------
    logic             rd_push, rd_pop, rd_full, rd_empty;
    logic             wr_push, wr_pop, wr_full, wr_empty;
    logic [IDX_W-1:0] rd_idx, wr_idx;

    assign rd_push = (cmd == CMD_RD) && bank_hit && !rd_full;
    assign wr_push = (cmd == CMD_WR) && bank_hit && !wr_full;
    // Emptiness is judged on the registered count, so a command pushed in
    // the same cycle cannot satisfy a data enable.
    assign rd_pop  = dfi_rddata_en && !rd_empty;
    assign wr_pop  = dfi_wrdata_en && !wr_empty;

    dfi_resp_fifo #(.WIDTH(IDX_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_push),
        .push_data (cmd_idx),
        .pop       (rd_pop),
        .pop_data  (rd_idx),
        .full      (rd_full),
        .empty     (rd_empty)
    );

    dfi_resp_fifo #(.WIDTH(IDX_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_push),
        .push_data (cmd_idx),
        .pop       (wr_pop),
        .pop_data  (wr_idx),
        .full      (wr_full),
        .empty     (wr_empty)
    );

    // ------------------------------------------------------------------
    // Bank state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_open <= '0;
        end else begin
            unique case (cmd)
                CMD_ACT: if (!bank_hit) bank_open[dfi_ba] <= 1'b1;
                CMD_PRE: begin
                    if (a10) bank_open <= '0;
                    else     bank_open[dfi_ba] <= 1'b0;
                end
                // Auto-precharge only applies to an access that was accepted.
                CMD_RD:  if (rd_push && a10) bank_open[dfi_ba] <= 1'b0;
                CMD_WR:  if (wr_push && a10) bank_open[dfi_ba] <= 1'b0;
                default: ;
            endcase
        end
    end

    // Row latch is only consulted while the bank is open, so it needs no reset.
    always_ff @(posedge clk) begin
        if (cmd == CMD_ACT && !bank_hit) begin
            open_row[dfi_ba] <= dfi_addr[ROW_IDX_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Backing store
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]      store_mem [STORE_DEPTH];
    logic [STORE_DEPTH-1:0] store_vld;

    // NOTE: the data array has no reset; only the valid bits are cleared,
    // which keeps this a plain RAM and still hides stale contents.
    always_ff @(posedge clk) begin
        if (wr_pop) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!dfi_wrdata_mask[b]) begin
                    store_mem[wr_idx][8*b +: 8] <= dfi_wrdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            store_vld <= '0;
        end else if (wr_pop) begin
            store_vld[wr_idx] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read return pipeline
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] beat_data;
    logic [MASK_W-1:0] beat_dnv;

    // Reads see the store as it was before this edge: a write popped in the
    // same cycle is not yet visible.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        beat_data = '0;
        beat_dnv  = '0;
        if (dfi_rddata_en) begin
            beat_dnv = '1;
            if (rd_pop && store_vld[rd_idx]) begin
                beat_data = store_mem[rd_idx];
                beat_dnv  = '0;
            end
        end
    end

    logic [RD_LAT-1:0] pipe_vld;
    logic [DATA_W-1:0] pipe_data [RD_LAT];
    logic [MASK_W-1:0] pipe_dnv  [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data[i] <= '0;
                pipe_dnv[i]  <= '0;
            end
        end else begin
            pipe_vld[0]  <= dfi_rddata_en;
            pipe_data[0] <= beat_data;
            pipe_dnv[0]  <= beat_dnv;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
                pipe_dnv[i]  <= pipe_dnv[i-1];
            end
        end
    end

    assign dfi_rddata_valid = pipe_vld[RD_LAT-1];
    assign dfi_rddata       = pipe_data[RD_LAT-1];
    assign dfi_rddata_dnv   = pipe_dnv[RD_LAT-1];

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic prot_set;
    logic ovf_set;

    assign prot_set = ((cmd == CMD_ACT) && bank_hit)
                    || (((cmd == CMD_RD) || (cmd == CMD_WR)) && !bank_hit)
                    || ((cmd == CMD_REF) && (|bank_open));
    assign ovf_set  = ((cmd == CMD_RD) && bank_hit && rd_full)
                    || ((cmd == CMD_WR) && bank_hit && wr_full);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_protocol  <= 1'b0;
            err_wr_orphan <= 1'b0;
            err_rd_orphan <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            if (prot_set)                   err_protocol  <= 1'b1;
            if (dfi_wrdata_en && wr_empty)  err_wr_orphan <= 1'b1;
            if (dfi_rddata_en && rd_empty)  err_rd_orphan <= 1'b1;
            if (ovf_set)                    err_overflow  <= 1'b1;
        end
    end

    // Address bits outside row LSBs / column group / A10 and the upper chip
    // selects carry no meaning for this model.
    logic unused_inputs;

`ifdef DFI_RESP_ODT_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_odt <= 1'b0;
        end else if (dfi_wrdata_en && !dfi_odt) begin
            err_odt <= 1'b1;
        end
    end
    assign unused_inputs = ^{dfi_addr, dfi_cs_n};
`else
    assign err_odt       = 1'b0;
    assign unused_inputs = ^{dfi_addr, dfi_cs_n, dfi_odt};
`endif

endmodule

// File: tb/tb_dfi_dram_responder.sv
// ----------------------------------------------------------------------------
// tb_dfi_dram_responder
// Directed scenarios followed by randomized traffic for dfi_dram_responder.
// A transaction-level reference model (bank table, store array, command
// queues, scheduled read beats) predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_dfi_dram_responder;

    localparam int BA_W    = 3;
    localparam int ADDR_W  = 14;
    localparam int CS_W    = 1;
    localparam int DEPTH   = 4;
    localparam int RD_LAT  = 2;
    localparam int NBANK   = 1 << BA_W;

    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_MRS = 3'b000;
    localparam logic [2:0] C_NOP = 3'b111;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dfi_cke;
    logic [CS_W-1:0]   dfi_cs_n;
    logic              dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic [BA_W-1:0]   dfi_ba;
    logic [ADDR_W-1:0] dfi_addr;
    logic              dfi_odt;
    logic              dfi_wrdata_en;
    logic [127:0]      dfi_wrdata;
    logic [15:0]       dfi_wrdata_mask;
    logic              dfi_rddata_en;
    logic [127:0]      dfi_rddata;
    logic              dfi_rddata_valid;
    logic [15:0]       dfi_rddata_dnv;
    logic              err_protocol, err_wr_orphan, err_rd_orphan, err_overflow, err_odt;

    always #5 clk = ~clk;

    dfi_dram_responder #(
        .BA_W(BA_W), .ADDR_W(ADDR_W), .CS_W(CS_W), .ROW_IDX_W(2), .COL_IDX_W(2),
        .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dfi_cke          (dfi_cke),
        .dfi_cs_n         (dfi_cs_n),
        .dfi_ras_n        (dfi_ras_n),
        .dfi_cas_n        (dfi_cas_n),
        .dfi_we_n         (dfi_we_n),
        .dfi_ba           (dfi_ba),
        .dfi_addr         (dfi_addr),
        .dfi_odt          (dfi_odt),
        .dfi_wrdata_en    (dfi_wrdata_en),
        .dfi_wrdata       (dfi_wrdata),
        .dfi_wrdata_mask  (dfi_wrdata_mask),
        .dfi_rddata_en    (dfi_rddata_en),
        .dfi_rddata       (dfi_rddata),
        .dfi_rddata_valid (dfi_rddata_valid),
        .dfi_rddata_dnv   (dfi_rddata_dnv),
        .err_protocol     (err_protocol),
        .err_wr_orphan    (err_wr_orphan),
        .err_rd_orphan    (err_rd_orphan),
        .err_overflow     (err_overflow),
        .err_odt          (err_odt)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        logic [127:0] data;
        logic [15:0]  dnv;
    } beat_t;

    bit           m_open  [NBANK];
    int           m_row   [NBANK];
    logic [127:0] m_store [64];
    bit           m_valid [64];
    int           m_rdq[$];
    int           m_wrq[$];
    beat_t        m_beats[$];
    // {protocol, wr_orphan, rd_orphan, overflow, odt}
    logic [4:0]   m_err;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NBANK; b++) begin
            m_open[b] = 0;
            m_row[b]  = 0;
        end
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
        m_rdq.delete();
        m_wrq.delete();
        m_beats.delete();
        m_err = '0;
    endtask

    // Apply one clock's worth of inputs to the model (edge number cyc+1).
    task automatic model_step();
        int    e;
        bit    rd_empty, wr_empty, rd_full, wr_full;
        int    idx, b;
        beat_t bt;
        e        = cyc + 1;
        rd_empty = (m_rdq.size() == 0);
        wr_empty = (m_wrq.size() == 0);
        rd_full  = (m_rdq.size() >= DEPTH);
        wr_full  = (m_wrq.size() >= DEPTH);
        if (!rst_n) begin
            model_reset();
            return;
        end
        // Reads observe the store before any same-cycle write.
        if (dfi_rddata_en) begin
            bt.due  = e + RD_LAT - 1;
            bt.data = '0;
            bt.dnv  = 16'hFFFF;
            if (!rd_empty) begin
                idx = m_rdq.pop_front();
                if (m_valid[idx]) begin
                    bt.data = m_store[idx];
                    bt.dnv  = 16'h0000;
                end
            end else begin
                m_err[2] = 1'b1;
            end
            m_beats.push_back(bt);
        end
        if (dfi_wrdata_en) begin
            if (!wr_empty) begin
                idx = m_wrq.pop_front();
                for (int k = 0; k < 16; k++)
                    if (!dfi_wrdata_mask[k]) m_store[idx][8*k +: 8] = dfi_wrdata[8*k +: 8];
                m_valid[idx] = 1;
            end else begin
                m_err[3] = 1'b1;
            end
`ifdef DFI_RESP_ODT_CHK_EN
            if (!dfi_odt) m_err[0] = 1'b1;
`endif
        end
        if (dfi_cke && !dfi_cs_n[0]) begin
            b = int'(dfi_ba);
            case ({dfi_ras_n, dfi_cas_n, dfi_we_n})
                C_ACT: begin
                    if (m_open[b]) m_err[4] = 1'b1;
                    else begin
                        m_open[b] = 1;
                        m_row[b]  = int'(dfi_addr);
                    end
                end
                C_RD, C_WR: begin
                    if (!m_open[b]) m_err[4] = 1'b1;
                    else if ((dfi_we_n ? rd_full : wr_full)) m_err[1] = 1'b1;
                    else begin
                        idx = (b % 4) * 16 + (m_row[b] % 4) * 4 + (int'(dfi_addr) / 8) % 4;
                        if (dfi_we_n) m_rdq.push_back(idx);
                        else          m_wrq.push_back(idx);
                        if (dfi_addr[10]) m_open[b] = 0;
                    end
                end
                C_PRE: begin
                    if (dfi_addr[10]) for (int j = 0; j < NBANK; j++) m_open[j] = 0;
                    else m_open[b] = 0;
                end
                C_REF: begin
                    for (int j = 0; j < NBANK; j++) if (m_open[j]) m_err[4] = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    // Advance one clock and compare every output with the model.
    task automatic tick();
        bit exp_vld;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        exp_vld = (m_beats.size() > 0) && (m_beats[0].due == cyc);
        check("rddata_valid", 128'(dfi_rddata_valid), 128'(exp_vld));
        if (exp_vld) begin
            check("rddata", dfi_rddata, m_beats[0].data);
            check("rddata_dnv", 128'(dfi_rddata_dnv), 128'(m_beats[0].dnv));
            void'(m_beats.pop_front());
        end
        check("err_flags",
              128'({err_protocol, err_wr_orphan, err_rd_orphan, err_overflow, err_odt}),
              128'(m_err));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        dfi_cke         = 1'b1;
        dfi_cs_n        = '0;
        {dfi_ras_n, dfi_cas_n, dfi_we_n} = C_NOP;
        dfi_ba          = '0;
        dfi_addr        = '0;
        dfi_odt         = 1'b1;
        dfi_wrdata_en   = 1'b0;
        dfi_wrdata      = '0;
        dfi_wrdata_mask = '0;
        dfi_rddata_en   = 1'b0;
    endtask

    task automatic do_cmd(input logic [2:0] rcw, input int b, input int a);
        set_idle();
        {dfi_ras_n, dfi_cas_n, dfi_we_n} = rcw;
        dfi_ba   = BA_W'(b);
        dfi_addr = ADDR_W'(a);
        tick();
    endtask

    task automatic do_wr_data(input logic [127:0] d, input logic [15:0] m);
        set_idle();
        dfi_wrdata_en   = 1'b1;
        dfi_wrdata      = d;
        dfi_wrdata_mask = m;
        tick();
    endtask

    task automatic do_rd_en();
        set_idle();
        dfi_rddata_en = 1'b1;
        tick();
    endtask

    task automatic idle_n(input int n);
        set_idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        set_idle();
        rst_n = 1'b0;
        do_reset();
        check("reset_rddata", dfi_rddata, 128'h0);
        check("reset_dnv", 128'(dfi_rddata_dnv), 128'h0);

        // 1: write then read back a full beat
        do_cmd(C_ACT, 1, 5);
        do_cmd(C_WR, 1, 'h08);
        do_wr_data({16{8'hA5}}, 16'h0000);
        do_cmd(C_RD, 1, 'h08);
        do_rd_en();
        tick();
        check("t1_data", dfi_rddata, {16{8'hA5}});
        check("t1_dnv", 128'(dfi_rddata_dnv), 128'h0);

        // 2: masked overwrite keeps low 8 bytes
        do_cmd(C_WR, 1, 'h08);
        do_wr_data(128'h0, 16'h00FF);
        do_cmd(C_RD, 1, 'h08);
        do_rd_en();
        tick();
        check("t2_data", dfi_rddata, {64'h0, {8{8'hA5}}});

        // 3: never-written location reads as not-valid
        do_cmd(C_ACT, 2, 3);
        do_cmd(C_RD, 2, 'h10);
        do_rd_en();
        tick();
        check("t3_dnv", 128'(dfi_rddata_dnv), 128'hFFFF);
        check("t3_no_err", 128'(err_protocol), 128'h0);

        // 4: RD to closed bank, then orphan read enable
        do_cmd(C_RD, 3, 'h00);
        check("t4_protocol", 128'(err_protocol), 128'h1);
        do_rd_en();
        check("t4_rd_orphan", 128'(err_rd_orphan), 128'h1);
        tick();
        check("t4_orphan_dnv", 128'(dfi_rddata_dnv), 128'hFFFF);

        // 5: WR FIFO overflow, then orphan write beat
        for (int i = 0; i < 4; i++) do_cmd(C_WR, 1, i * 8);
        check("t5_no_ovf", 128'(err_overflow), 128'h0);
        do_cmd(C_WR, 1, 0);
        check("t5_overflow", 128'(err_overflow), 128'h1);
        for (int i = 0; i < 4; i++) do_wr_data(128'(i + 1), 16'h0);
        check("t5_no_wr_orphan", 128'(err_wr_orphan), 128'h0);
        do_wr_data(128'hDEAD, 16'h0);
        check("t5_wr_orphan", 128'(err_wr_orphan), 128'h1);

        // 6: REF with open banks; legal REF after PRE-all; ODT check
        do_reset();
        do_cmd(C_ACT, 0, 1);
        do_cmd(C_ACT, 4, 2);
        do_cmd(C_REF, 0, 0);
        check("t6_ref_open", 128'(err_protocol), 128'h1);
        do_reset();
        do_cmd(C_ACT, 0, 1);
        do_cmd(C_PRE, 0, 'h400);
        do_cmd(C_REF, 0, 0);
        check("t6_ref_ok", 128'(err_protocol), 128'h0);
        set_idle();
        dfi_wrdata_en = 1'b1;
        dfi_odt       = 1'b0;
        tick();
`ifdef DFI_RESP_ODT_CHK_EN
        check("t6_odt", 128'(err_odt), 128'h1);
`else
        check("t6_odt_off", 128'(err_odt), 128'h0);
`endif

        // Same-cycle write pop and read pop of one index: read sees old data
        do_reset();
        do_cmd(C_ACT, 1, 6);
        do_cmd(C_WR, 1, 'h18);
        do_wr_data({16{8'h3C}}, 16'h0);
        do_cmd(C_WR, 1, 'h18);
        do_cmd(C_RD, 1, 'h18);
        set_idle();
        dfi_wrdata_en = 1'b1;
        dfi_wrdata    = {16{8'hC3}};
        dfi_rddata_en = 1'b1;
        tick();
        tick();
        check("same_cycle_old", dfi_rddata, {16{8'h3C}});

        // Back-to-back reads and reset flushing the pipeline
        do_cmd(C_RD, 1, 'h18);
        do_cmd(C_RD, 1, 'h18);
        do_rd_en();
        do_rd_en();
        idle_n(3);
        do_cmd(C_RD, 1, 'h18);
        do_rd_en();
        do_reset();
        check("flush_no_beat", 128'(dfi_rddata_valid), 128'h0);
        idle_n(3);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] cmds [7];
            cmds = '{C_ACT, C_RD, C_WR, C_PRE, C_REF, C_MRS, C_NOP};
            set_idle();
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            dfi_cke  = ($urandom_range(0, 9) != 0);
            dfi_cs_n = CS_W'($urandom_range(0, 9) == 0);
            {dfi_ras_n, dfi_cas_n, dfi_we_n} = cmds[$urandom_range(0, 6)];
            dfi_ba          = BA_W'($urandom_range(0, NBANK - 1));
            dfi_addr        = ADDR_W'($urandom_range(0, 63));
            dfi_addr[10]    = ($urandom_range(0, 3) == 0);
            dfi_odt         = ($urandom_range(0, 9) != 0);
            dfi_wrdata_en   = ($urandom_range(0, 2) == 0);
            dfi_wrdata      = {$urandom, $urandom, $urandom, $urandom};
            dfi_wrdata_mask = 16'($urandom);
            dfi_rddata_en   = ($urandom_range(0, 2) == 0);
            tick();
        end
        idle_n(RD_LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
